// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Bundles the load handshake, shift tick, frame configuration and serial
//   outputs of uart_tx_serializer. CLK/RST stay plain ports on the module.
//
//   Handshake: a load is accepted on a rising CLK edge where ld && ready.
//   P_DATA, MSB_FIRST, PAR_EN and PAR_TYP are sampled only on that edge.
//   ld while ready=0 is dropped, not queued.
//
//   master : driver side (TX FSM / testbench)
//   slave  : serializer side
//   dbg_state exposes the serializer FSM state for checkers.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  ld;
  logic                  ser_en;
  logic                  MSB_FIRST;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ready;
  logic                  ser_data;
  logic                  par_bit;
  logic                  ser_done;
  logic [1:0]            dbg_state;

  modport master (
    output P_DATA, ld, ser_en, MSB_FIRST, PAR_EN, PAR_TYP,
    input  ready, ser_data, par_bit, ser_done, dbg_state
  );

  modport slave (
    input  P_DATA, ld, ser_en, MSB_FIRST, PAR_EN, PAR_TYP,
    output ready, ser_data, par_bit, ser_done, dbg_state
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART TX serializer with optional parity. Loads a DATA_WIDTH-bit word on
//   the ld/ready handshake, emits one bit per ser_en tick (LSB or MSB first),
//   optionally follows with a parity bit, and pulses ser_done for one cycle
//   together with the final bit.
//
//   Ports:
//     CLK  - rising-edge clock
//     RST  - synchronous active-low reset
//     bus  - uart_tx_serializer_if.slave (P_DATA, ld, ser_en, MSB_FIRST,
//            PAR_EN, PAR_TYP in; ready, ser_data, par_bit, ser_done,
//            dbg_state out)
//
//   Build option: define UART_SER_PARITY_EN to include the parity generator
//   and PARITY state. Without it par_bit is 0, PAR_EN/PAR_TYP are ignored and
//   every frame is exactly DATA_WIDTH bits.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  msb_q, msb_d;
  logic                  ser_data_q, ser_data_d;
  logic                  par_bit_q, par_bit_d;
  logic                  done_q, done_d;
`ifdef UART_SER_PARITY_EN
  logic                  pen_q, pen_d;
`else
  // Parity inputs have no function in this build.
  logic                  unused_par;
  assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    msb_d      = msb_q;
    ser_data_d = ser_data_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
`ifdef UART_SER_PARITY_EN
    pen_d      = pen_q;
`endif
    case (state_q)
      IDLE: begin
        // ser_en in the load cycle is ignored: first bit goes on a later tick.
        if (bus.ld) begin
          shreg_d = bus.P_DATA;
          msb_d   = bus.MSB_FIRST;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef UART_SER_PARITY_EN
          pen_d     = bus.PAR_EN;
          par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
        end
      end
      SHIFT: begin
        if (bus.ser_en) begin
          // Emit from the chosen end, then shift toward that end.
          if (msb_q) begin
            ser_data_d = shreg_q[DATA_WIDTH-1];
            shreg_d    = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            ser_data_d = shreg_q[0];
            shreg_d    = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_SER_PARITY_EN
            if (pen_q) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      PARITY: begin
        if (bus.ser_en) begin
          ser_data_d = par_bit_q;
          state_d    = IDLE;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      ser_data_q <= 1'b1;
      par_bit_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_SER_PARITY_EN
      pen_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      msb_q      <= msb_d;
      ser_data_q <= ser_data_d;
      par_bit_q  <= par_bit_d;
      done_q     <= done_d;
`ifdef UART_SER_PARITY_EN
      pen_q      <= pen_d;
`endif
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.ser_data  = ser_data_q;
  assign bus.par_bit   = par_bit_q;
  assign bus.ser_done  = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  localparam int W = 8;
`ifdef UART_SER_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic last_bit;
  logic last_par;

  uart_tx_serializer_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Mid-frame noise: stray loads and configuration changes that must be ignored.
  task automatic scramble();
    bus.ld        = 1'($urandom_range(0, 1));
    bus.P_DATA    = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
    bus.MSB_FIRST = 1'($urandom_range(0, 1));
    bus.PAR_EN    = 1'($urandom_range(0, 1));
    bus.PAR_TYP   = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.ld     = 1'b0;
      bus.ser_en = 1'($urandom_range(0, 1));
      cyc();
      chk("idle_done", 32'(bus.ser_done), 32'(0));
      chk("idle_ready", 32'(bus.ready), 32'(1));
      chk("idle_hold", 32'(bus.ser_data), 32'(last_bit));
      chk("idle_par", 32'(bus.par_bit), 32'(last_par));
    end
  endtask

  // One frame: load, then emit with 'gap' idle cycles before each tick
  // (gap<0 = random gap). abort_after>0 resets after that many bits.
  task automatic run_frame(input logic [W-1:0] data, input bit msb, input bit pen,
                           input bit ptyp, input int gap, input int abort_after);
    logic [0:0] exp_q[$];
    logic       exp_par;
    int         g;
    int         n;
    logic [0:0] b;

    // Reference frame: data bits in requested order, then optional parity.
    exp_par = PAR_BUILD ? ((^data) ^ ptyp) : 1'b0;
    for (int i = 0; i < W; i++)
      exp_q.push_back(msb ? data[W-1-i] : data[i]);
    if (PAR_BUILD && pen)
      exp_q.push_back(exp_par);

    bus.P_DATA    = data;
    bus.MSB_FIRST = msb;
    bus.PAR_EN    = pen;
    bus.PAR_TYP   = ptyp;
    bus.ld        = 1'b1;
    bus.ser_en    = 1'($urandom_range(0, 1));
    cyc();
    last_par = exp_par;
    chk("load_ready", 32'(bus.ready), 32'(0));
    chk("load_par", 32'(bus.par_bit), 32'(exp_par));
    chk("load_hold", 32'(bus.ser_data), 32'(last_bit));
    chk("load_done", 32'(bus.ser_done), 32'(0));

    n = 0;
    while (exp_q.size() > 0) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int j = 0; j < g; j++) begin
        scramble();
        bus.ser_en = 1'b0;
        cyc();
        chk("gap_hold", 32'(bus.ser_data), 32'(last_bit));
        chk("gap_done", 32'(bus.ser_done), 32'(0));
        chk("gap_ready", 32'(bus.ready), 32'(0));
      end
      scramble();
      bus.ser_en = 1'b1;
      cyc();
      b = exp_q.pop_front();
      last_bit = b;
      n++;
      chk("bit", 32'(bus.ser_data), 32'(b));
      chk("bit_done", 32'(bus.ser_done), 32'(exp_q.size() == 0));
      chk("bit_ready", 32'(bus.ready), 32'(exp_q.size() == 0));
      chk("bit_par", 32'(bus.par_bit), 32'(exp_par));
      if (n == abort_after) begin
        bus.ld     = 1'b0;
        bus.ser_en = 1'b0;
        RST        = 1'b0;
        cyc();
        RST      = 1'b1;
        last_bit = 1'b1;
        last_par = 1'b0;
        chk("abort_ready", 32'(bus.ready), 32'(1));
        chk("abort_ser", 32'(bus.ser_data), 32'(1));
        chk("abort_done", 32'(bus.ser_done), 32'(0));
        chk("abort_par", 32'(bus.par_bit), 32'(0));
        exp_q.delete();
      end
    end
    bus.ld     = 1'b0;
    bus.ser_en = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    RST           = 1'b0;
    bus.P_DATA    = '0;
    bus.ld        = 1'b0;
    bus.ser_en    = 1'b0;
    bus.MSB_FIRST = 1'b0;
    bus.PAR_EN    = 1'b0;
    bus.PAR_TYP   = 1'b0;
    last_bit      = 1'b1;
    last_par      = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_ser", 32'(bus.ser_data), 32'(1));
    chk("rst_par", 32'(bus.par_bit), 32'(0));
    chk("rst_done", 32'(bus.ser_done), 32'(0));
    RST = 1'b1;
    idle(2);

    // LSB-first, even parity, tick every cycle
    run_frame(8'hC1, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(2);
    // MSB-first, odd parity
    run_frame(8'hC1, 1'b1, 1'b1, 1'b1, 0, -1);
    idle(1);
    // no parity, tick one cycle in four
    run_frame(8'hC1, 1'b0, 1'b0, 1'b0, 3, -1);
    idle(1);
    // back-to-back: second load in the ser_done cycle
    run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0, -1);
    run_frame(8'h00, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(1);
    // reset after the third bit, then a full frame
    run_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1, 3);
    idle(1);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1, -1);
    idle(1);

    // random frames, sometimes back-to-back
    for (int f = 0; f < 12; f++) begin
      run_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1);
      if ($urandom_range(0, 1) == 1)
        idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
